// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared GPU memory-op constants and default memory geometry
package mem_port_arbiter_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rtl/mem_port_arbiter_rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_index,
  output logic               grant_valid
);

  always_comb begin
    logic [IW-1:0] sel;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    sel         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && request[sel]) begin
        grant_valid = 1'b1;
        grant[sel]  = 1'b1;
        grant_index = sel;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one single-port memory with registered read responses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int DEPTH   = DEFAULT_DEPTH,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*AW-1:0]    req_address,
  input  logic [NUM_REQ*WIDTH-1:0] req_w_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_r_data,
  output logic [AW-1:0]            mem_address,
  output logic [WIDTH-1:0]         mem_w_data,
  output logic                     mem_w_write,
  input  logic [WIDTH-1:0]         mem_r_data
);

  logic [IW-1:0]      last_grant;
  logic [NUM_REQ-1:0] active_req;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_index;
  logic               grant_valid;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [WIDTH-1:0]   resp_r_data_q;

  // Masking requests during reset keeps every grant-derived output quiet.
  assign active_req = reset ? '0 : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .request     (active_req),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  always_comb begin
    mem_address = '0;
    mem_w_data  = '0;
    mem_w_write = 1'b0;
    if (grant_valid) begin
      mem_address = req_address[int'(grant_index)*AW +: AW];
      mem_w_data  = req_w_data[int'(grant_index)*WIDTH +: WIDTH];
      mem_w_write = (req_write[grant_index] == OP_WRITE);
    end
  end

  // A read that completed just before reset must not surface while reset is held.
  assign resp_valid  = reset ? '0 : resp_valid_q;
  assign resp_r_data = reset ? '0 : resp_r_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= IW'(NUM_REQ - 1);
      resp_valid_q  <= '0;
      resp_r_data_q <= '0;
    end else begin
      resp_valid_q <= '0;
      if (grant_valid) begin
        last_grant <= grant_index;
        if (req_write[grant_index] == OP_READ) begin
          resp_valid_q  <= grant;
          resp_r_data_q <= mem_r_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 1024;
  localparam int AW      = 10;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ*AW-1:0]    req_address;
  logic [NUM_REQ*WIDTH-1:0] req_w_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_r_data;
  logic [AW-1:0]            mem_address;
  logic [WIDTH-1:0]         mem_w_data;
  logic                     mem_w_write;
  logic [WIDTH-1:0]         mem_r_data;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_vec  = 0;
  int n_miss = 0;

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_address (req_address),
    .req_w_data  (req_w_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_r_data (resp_r_data),
    .mem_address (mem_address),
    .mem_w_data  (mem_w_data),
    .mem_w_write (mem_w_write),
    .mem_r_data  (mem_r_data)
  );

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_address];
  always @(posedge clk) if (mem_w_write) mem[mem_address] <= mem_w_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid[i]               = v;
    req_write[i]               = w;
    req_address[i*AW +: AW]    = a;
    req_w_data[i*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = 16'h0010 + 16'(i);
    reset       = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_address = '0;
    req_w_data  = '0;

    // Reset held with every requester valid
    step();
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_wwrite", 32'(mem_w_write), 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data", 32'(resp_r_data), 32'h0);
      step();
    end
    reset     = 1'b0;
    req_valid = '0;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_addr", 32'(mem_address), 32'h0);

    // Write then read-back by requester 2
    set_cmd(2, 1'b1, 1'b1, 10'd5, 16'hBEEF);
    #1;
    check("wr_ready", 32'(req_ready), 32'h4);
    check("wr_wwrite", 32'(mem_w_write), 32'h1);
    check("wr_addr", 32'(mem_address), 32'h5);
    check("wr_wdata", 32'(mem_w_data), 32'hBEEF);
    step();
    set_cmd(2, 1'b1, 1'b0, 10'd5, 16'h0000);
    #1;
    check("rd_ready", 32'(req_ready), 32'h4);
    check("rd_wwrite", 32'(mem_w_write), 32'h0);
    check("after_wr_resp", 32'(resp_valid), 32'h0);
    step();
    set_cmd(2, 1'b0, 1'b0, 10'd0, 16'h0000);
    #1;
    check("rd_resp_valid", 32'(resp_valid), 32'h4);
    check("rd_resp_data", 32'(resp_r_data), 32'hBEEF);
    step();
    check("idle_resp_valid", 32'(resp_valid), 32'h0);
    check("hold_resp_data", 32'(resp_r_data), 32'hBEEF);

    // Fresh pointer, then all four read addresses 0..3
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 1'b0, AW'(i), 16'h0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr4_ready", 32'(req_ready), 32'(1 << (k % 4)));
      check("rr4_addr", 32'(mem_address), 32'(k % 4));
      step();
      check("rr4_resp_valid", 32'(resp_valid), 32'(1 << (k % 4)));
      check("rr4_resp_data", 32'(resp_r_data), 32'h10 + 32'(k % 4));
    end

    // Pointer to 0, then requesters 1 and 3 compete
    req_valid = 4'b0001;
    #1;
    check("pre_alt_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("alt_ready", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      step();
    end

    // Read granted just before reset yields no response
    req_valid = 4'b0001;
    set_cmd(0, 1'b1, 1'b0, 10'd1, 16'h0);
    #1;
    check("pre_rst_ready", 32'(req_ready), 32'h1);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_resp_data", 32'(resp_r_data), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("post_rst_ready", 32'(req_ready), 32'h1);

    // Requester 0 alone: back-to-back grants, latency 1
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_cmd(0, 1'b1, 1'b0, AW'(k), 16'h0);
      #1;
      check("solo_ready", 32'(req_ready), 32'h1);
      check("solo_addr", 32'(mem_address), 32'(k));
      step();
      check("solo_resp_valid", 32'(resp_valid), 32'h1);
      check("solo_resp_data", 32'(resp_r_data), 32'h10 + 32'(k));
    end
    req_valid = '0;
    step();
    check("final_resp_valid", 32'(resp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
